// File: rtl/counter_pkg.sv
// Shared types and helpers for the synchronous up/down counter.
package counter_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  function automatic int unsigned clamp_mod(input int unsigned value, input int unsigned mod);
    return (value >= mod) ? (mod - 1) : value;
  endfunction

endpackage

// File: rtl/sync_updown_counter_if.sv
// Control/status bundle for sync_updown_counter.
interface sync_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;

  modport master (output en, up, clr, load, load_val, input out, tc);
  modport slave  (input en, up, clr, load, load_val, output out, tc);
endinterface

// File: rtl/cnt_prescaler.sv
// Step-enable divider: tick fires on the last phase of each PRESCALE-cycle group while en=1.
module cnt_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_bypass
    logic unused_ins;
    assign unused_ins = &{1'b0, clk, rstn, en, sync_clr};
    assign tick = 1'b1;
  end else begin : g_div
    localparam int unsigned PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_p1;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        phase_p1 <= '0;
      end else if (sync_clr) begin
        phase_p1 <= '0;
      end else if (en) begin
        phase_p1 <= (phase_p1 == LAST) ? '0 : phase_p1 + 1'b1;
      end
    end

    assign tick = en && (phase_p1 == LAST);
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous modulo up/down counter with load, clear, prescaled stepping and tc pulse.
// Define UDCNT_SATURATE_EN to hold at the boundaries instead of wrapping.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MOD      = 16,
  parameter int unsigned PRESCALE = 1
) (
  input logic                  clk,
  input logic                  rstn,
  sync_updown_counter_if.slave bus
);

  localparam int unsigned MOD_C = clamp_mod(MOD, (32'd1 << WIDTH) + 32'd1);
  localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MOD_C);
  localparam logic [WIDTH:0] ONE_W  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] LAST_W = MOD_W - ONE_W;
`ifdef UDCNT_SATURATE_EN
  localparam logic [WIDTH:0] WRAP_UP = LAST_W;
  localparam logic [WIDTH:0] WRAP_DN = '0;
`else
  localparam logic [WIDTH:0] WRAP_UP = '0;
  localparam logic [WIDTH:0] WRAP_DN = LAST_W;
`endif

  logic             tick;
  logic             step;
  cnt_dir_e         dir;
  logic [WIDTH:0]   cur;
  logic [WIDTH:0]   nxt;
  logic             wrap;
  logic [WIDTH-1:0] load_c;
  logic [WIDTH-1:0] cnt_p1;
  logic             tc_p1;
  logic             unused_msb;

  cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk      (clk),
    .rstn     (rstn),
    .en       (bus.en),
    .sync_clr (bus.clr | bus.load),
    .tick     (tick)
  );

  assign step   = bus.en & tick;
  assign dir    = cnt_dir_e'(bus.up);
  assign load_c = WIDTH'(clamp_mod(32'(bus.load_val), MOD_C));

  // Next-count arithmetic is one bit wider so MOD == 2**WIDTH compares correctly.
  always_comb begin
    cur  = {1'b0, cnt_p1};
    nxt  = cur;
    wrap = 1'b0;
    if (dir == CNT_UP) begin
      if ((cur + ONE_W) >= MOD_W) begin
        wrap = 1'b1;
        nxt  = WRAP_UP;
      end else begin
        nxt = cur + ONE_W;
      end
    end else begin
      if (cur == '0) begin
        wrap = 1'b1;
        nxt  = WRAP_DN;
      end else begin
        nxt = cur - ONE_W;
      end
    end
  end

  assign unused_msb = nxt[WIDTH];

  // Stage p1: registered count and terminal-count pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_p1 <= '0;
      tc_p1  <= 1'b0;
    end else if (bus.clr) begin
      cnt_p1 <= '0;
      tc_p1  <= 1'b0;
    end else if (bus.load) begin
      cnt_p1 <= load_c;
      tc_p1  <= 1'b0;
    end else if (step) begin
      cnt_p1 <= nxt[WIDTH-1:0];
      tc_p1  <= wrap;
    end else begin
      tc_p1  <= 1'b0;
    end
  end

  assign bus.out = cnt_p1;
  assign bus.tc  = tc_p1;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter (MOD=10, PRESCALE=1 and PRESCALE=3 instances).
module tb_sync_updown_counter;

  logic clk;
  logic rstn;
  int   passed;
  int   total;

  sync_updown_counter_if #(.WIDTH(4)) if0 ();
  sync_updown_counter_if #(.WIDTH(4)) if3 ();

  sync_updown_counter #(.WIDTH(4), .MOD(10), .PRESCALE(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if0.slave)
  );

  sync_updown_counter #(.WIDTH(4), .MOD(10), .PRESCALE(3)) dut3 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    total++; if (if0.out !== 4'd0) $display("FAIL rst_out got %0d exp 0", if0.out); else passed++;
    total++; if (if0.tc !== 1'b0) $display("FAIL rst_tc got %0b exp 0", if0.tc); else passed++;
    total++; if (if3.out !== 4'd0) $display("FAIL rst_out3 got %0d exp 0", if3.out); else passed++;
    tick1();
    rstn = 1'b1;
    if0.en = 1'b1; if0.up = 1'b1;
    repeat (7) tick1();
    total++; if (if0.out !== 4'd7) $display("FAIL pre_rst_out got %0d exp 7", if0.out); else passed++;
    rstn = 1'b0;
    #1;
    total++; if (if0.out !== 4'd0) $display("FAIL midrst_out got %0d exp 0", if0.out); else passed++;
    total++; if (if0.tc !== 1'b0) $display("FAIL midrst_tc got %0b exp 0", if0.tc); else passed++;
    if0.en = 1'b0;
    #1;
    rstn = 1'b1;
    tick1();
  endtask

  task automatic test_count_up();
    logic [3:0] exp_out [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic       exp_tc  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    total++; if (if0.out !== 4'd0) $display("FAIL up_start got %0d exp 0", if0.out); else passed++;
    if0.en = 1'b1; if0.up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick1();
      total++; if (if0.out !== exp_out[i]) $display("FAIL up_out[%0d] got %0d exp %0d", i, if0.out, exp_out[i]); else passed++;
      total++; if (if0.tc !== exp_tc[i]) $display("FAIL up_tc[%0d] got %0b exp %0b", i, if0.tc, exp_tc[i]); else passed++;
    end
    if0.en = 1'b0;
  endtask

  task automatic test_count_down();
    logic [3:0] exp_out [6] = '{4'd0, 4'd9, 4'd8, 4'd8, 4'd8, 4'd8};
    logic       exp_tc  [6] = '{0, 1, 0, 0, 0, 0};
    logic       en_vec  [6] = '{1, 1, 1, 0, 0, 0};
    if0.load = 1'b1; if0.load_val = 4'd1;
    tick1();
    if0.load = 1'b0;
    total++; if (if0.out !== 4'd1) $display("FAIL dn_load got %0d exp 1", if0.out); else passed++;
    if0.up = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if0.en = en_vec[i];
      tick1();
      total++; if (if0.out !== exp_out[i]) $display("FAIL dn_out[%0d] got %0d exp %0d", i, if0.out, exp_out[i]); else passed++;
      total++; if (if0.tc !== exp_tc[i]) $display("FAIL dn_tc[%0d] got %0b exp %0b", i, if0.tc, exp_tc[i]); else passed++;
    end
    if0.en = 1'b0;
  endtask

  task automatic test_load_clr();
    if0.load = 1'b1; if0.load_val = 4'd14;
    tick1();
    total++; if (if0.out !== 4'd9) $display("FAIL ld14_out got %0d exp 9", if0.out); else passed++;
    total++; if (if0.tc !== 1'b0) $display("FAIL ld14_tc got %0b exp 0", if0.tc); else passed++;
    if0.load_val = 4'd0;
    tick1();
    total++; if (if0.out !== 4'd0) $display("FAIL ld0_out got %0d exp 0", if0.out); else passed++;
    total++; if (if0.tc !== 1'b0) $display("FAIL ld0_tc got %0b exp 0", if0.tc); else passed++;
    if0.load_val = 4'd10;
    tick1();
    total++; if (if0.out !== 4'd9) $display("FAIL ld10_out got %0d exp 9", if0.out); else passed++;
    if0.load_val = 4'd5;
    tick1();
    total++; if (if0.out !== 4'd5) $display("FAIL ld5_out got %0d exp 5", if0.out); else passed++;
    if0.clr = 1'b1; if0.load_val = 4'd6; if0.en = 1'b1; if0.up = 1'b1;
    tick1();
    total++; if (if0.out !== 4'd0) $display("FAIL clr_ld_out got %0d exp 0", if0.out); else passed++;
    total++; if (if0.tc !== 1'b0) $display("FAIL clr_ld_tc got %0b exp 0", if0.tc); else passed++;
    if0.clr = 1'b0; if0.load = 1'b0; if0.en = 1'b0;
  endtask

  task automatic test_prescale();
    logic       en_vec  [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    logic [3:0] exp_out [10] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
    if3.up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if3.en = en_vec[i];
      tick1();
      total++; if (if3.out !== exp_out[i]) $display("FAIL ps_out[%0d] got %0d exp %0d", i, if3.out, exp_out[i]); else passed++;
      total++; if (if3.tc !== 1'b0) $display("FAIL ps_tc[%0d] got %0b exp 0", i, if3.tc); else passed++;
    end
    if3.en = 1'b0;
  endtask

  task automatic test_saturate();
    if0.load = 1'b1; if0.load_val = 4'd9;
    tick1();
    if0.load = 1'b0; if0.en = 1'b1; if0.up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick1();
      total++; if (if0.out !== 4'd9) $display("FAIL sat_up_out[%0d] got %0d exp 9", i, if0.out); else passed++;
      total++; if (if0.tc !== 1'b1) $display("FAIL sat_up_tc[%0d] got %0b exp 1", i, if0.tc); else passed++;
    end
    if0.up = 1'b0;
    tick1();
    total++; if (if0.out !== 4'd8) $display("FAIL sat_dn_out got %0d exp 8", if0.out); else passed++;
    total++; if (if0.tc !== 1'b0) $display("FAIL sat_dn_tc got %0b exp 0", if0.tc); else passed++;
    if0.en = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rstn = 1'b0;
    if0.en = 1'b0; if0.up = 1'b1; if0.clr = 1'b0; if0.load = 1'b0; if0.load_val = '0;
    if3.en = 1'b0; if3.up = 1'b1; if3.clr = 1'b0; if3.load = 1'b0; if3.load_val = '0;
    test_reset();
`ifdef UDCNT_SATURATE_EN
    test_saturate();
`else
    test_count_up();
    test_count_down();
`endif
    test_load_clr();
    test_prescale();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
